// File: rtl/sip_round_counter_if.sv
// Control/status bundle between the SipHash control FSM (master) and the
// round sequencer (slave).
interface sip_round_counter_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] c_rounds;
   logic [WIDTH-1:0] d_rounds;
   logic             hold;
   logic             abort;
   logic             busy;
   logic             round_en;
   logic [WIDTH-1:0] round_idx;
   logic             last_round;
   logic             phase;
   logic             done;
   logic             ovr;

   modport master (
      output start, mode, c_rounds, d_rounds, hold, abort,
      input  busy, round_en, round_idx, last_round, phase, done, ovr
   );

   modport slave (
      input  start, mode, c_rounds, d_rounds, hold, abort,
      output busy, round_en, round_idx, last_round, phase, done, ovr
   );
endinterface

// File: rtl/sip_round_counter.sv
// Round sequencer for the SipHash core: runs c_rounds or d_rounds SipRounds
// per start, with hold/stall, abort, a done pulse and an overrun flag.
module sip_round_counter #(
   parameter int WIDTH      = 4,
   parameter bit STICKY_OVR = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   sip_round_counter_if.slave bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] IDX_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] IDX_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [WIDTH-1:0] idx_r, idx_s;
   logic [WIDTH-1:0] n_r, n_s;
   logic [WIDTH-1:0] n_sel_s, n_last_s;
   logic             phase_r, phase_s;
   logic             done_r, done_s;
   logic             ovr_r, ovr_s;
   logic             busy_s;

   assign n_sel_s  = bus.mode ? bus.d_rounds : bus.c_rounds;
   assign n_last_s = n_r - IDX_ONE;
   assign busy_s   = (state_r == ST_RUN);

   // Next-state logic: abort beats start/hold; a zero-round request completes in IDLE.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      n_s     = n_r;
      phase_s = phase_r;
      done_s  = 1'b0;
      ovr_s   = STICKY_OVR ? ovr_r : 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.abort) begin
               idx_s = IDX_ZERO;
            end else if (bus.start) begin
               n_s     = n_sel_s;
               phase_s = bus.mode;
               idx_s   = IDX_ZERO;
               if (n_sel_s != IDX_ZERO) begin
                  state_s = ST_RUN;
               end else begin
                  done_s = 1'b1;
               end
            end else begin
               idx_s = IDX_ZERO;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_s = ST_IDLE;
               idx_s   = IDX_ZERO;
            end else begin
               if (bus.start) begin
                  ovr_s = 1'b1;
               end else begin
                  ovr_s = STICKY_OVR ? ovr_r : 1'b0;
               end
               // Indices stop at N-1, so the counter can never wrap.
               if (bus.hold) begin
                  idx_s = idx_r;
               end else if (idx_r == n_last_s) begin
                  state_s = ST_IDLE;
                  idx_s   = IDX_ZERO;
                  done_s  = 1'b1;
               end else begin
                  idx_s = idx_r + IDX_ONE;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = IDX_ZERO;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= IDX_ZERO;
         n_r     <= IDX_ZERO;
         phase_r <= 1'b0;
         done_r  <= 1'b0;
         ovr_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         n_r     <= n_s;
         phase_r <= phase_s;
         done_r  <= done_s;
         ovr_r   <= ovr_s;
      end
   end

   assign bus.busy       = busy_s;
   assign bus.round_en   = busy_s & ~bus.hold;
   assign bus.round_idx  = idx_r;
   assign bus.last_round = busy_s & (idx_r == n_last_s);
   assign bus.phase      = phase_r;
   assign bus.done       = done_r;
   assign bus.ovr        = ovr_r;
endmodule

// File: tb/tb_sip_round_counter.sv
// Scoreboard bench for sip_round_counter: hand-derived per-cycle expectations
// are queued as stimulus is driven and compared one cycle later.
module tb_sip_round_counter;
   logic clk;
   logic rst_n;
   int   err_cnt;
   int   chk_cnt;

   typedef struct {
      logic       busy;
      logic       en;
      logic [3:0] idx;
      logic       last;
      logic       phase;
      logic       done;
      logic       ovr;
   } exp_t;

   exp_t exp_q[$];

   sip_round_counter_if #(.WIDTH(4)) bus ();

   sip_round_counter #(.WIDTH(4), .STICKY_OVR(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic md, input logic [3:0] cr,
                        input logic [3:0] dr, input logic hd, input logic ab);
      bus.start    = st;
      bus.mode     = md;
      bus.c_rounds = cr;
      bus.d_rounds = dr;
      bus.hold     = hd;
      bus.abort    = ab;
   endtask

   // Queue what the outputs must look like after the next edge, then clock and compare.
   task automatic cyc(input string tag, input logic busy, input logic [3:0] idx,
                      input logic last, input logic ph, input logic dn, input logic ov);
      exp_t e;
      exp_t o;
      e.busy = busy; e.idx = idx; e.last = last; e.phase = ph; e.done = dn; e.ovr = ov;
      e.en   = busy & ~bus.hold;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      o = exp_q.pop_front();
      check({tag, ".busy"},  {31'd0, bus.busy},       {31'd0, o.busy});
      check({tag, ".en"},    {31'd0, bus.round_en},   {31'd0, o.en});
      check({tag, ".idx"},   {28'd0, bus.round_idx},  {28'd0, o.idx});
      check({tag, ".last"},  {31'd0, bus.last_round}, {31'd0, o.last});
      check({tag, ".phase"}, {31'd0, bus.phase},      {31'd0, o.phase});
      check({tag, ".done"},  {31'd0, bus.done},       {31'd0, o.done});
      check({tag, ".ovr"},   {31'd0, bus.ovr},        {31'd0, o.ovr});
   endtask

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      rst_n   = 1'b0;
      drive(1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0);
      cyc("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Two compression rounds.
      drive(1'b1, 1'b0, 4'd2, 4'd9, 1'b0, 1'b0);
      cyc("c2_r0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd2, 4'd9, 1'b0, 1'b0);
      cyc("c2_r1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("c2_dn", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("c2_qt", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Four finalization rounds with two stalled cycles at index 1.
      drive(1'b1, 1'b1, 4'd7, 4'd4, 1'b0, 1'b0);
      cyc("d4_r0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'd7, 4'd4, 1'b0, 1'b0);
      cyc("d4_r1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0);
      cyc("d4_h1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("d4_h2", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
      cyc("d4_r2", 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("d4_r3", 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("d4_dn", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Zero rounds: done straight from IDLE.
      drive(1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
      cyc("z_dn", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
      cyc("z_qt", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Overrun start at index 1, then back-to-back start in the done cycle.
      drive(1'b1, 1'b0, 4'd3, 4'd2, 1'b0, 1'b0);
      cyc("o_r0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd3, 4'd2, 1'b0, 1'b0);
      cyc("o_r1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
      cyc("o_r2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0);
      cyc("o_dn", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0);
      cyc("b2b_r0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0);
      cyc("b2b_r1", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("b2b_dn", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Abort with simultaneous start at index 2, then abort+start in IDLE.
      drive(1'b1, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0);
      cyc("a_r0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0);
      cyc("a_r1", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("a_r2", 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 4'd2, 4'd4, 1'b1, 1'b1);
      cyc("a_ab", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("a_idl", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0);
      cyc("a_qt", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a 15-round sequence clears everything, ovr included.
      drive(1'b1, 1'b1, 4'd1, 4'd15, 1'b0, 1'b0);
      cyc("m_r0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 4'd1, 4'd15, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) cyc("m_rn", 1'b1, 4'(i), 1'b0, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      cyc("m_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Full-width count: indices 0..14 with no wrap.
      drive(1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0);
      cyc("f_r0", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++) cyc("f_rn", 1'b1, 4'(i), (i == 14), 1'b1, 1'b0, 1'b0);
      cyc("f_dn", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("f_qt", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/sip_round_counter.md
Name: sip_round_counter

Overview:
- Parametrised round sequencer for the SipHash core; successor to the fixed 4-bit countdown.
- Counts a runtime-selected number of rounds: c_rounds for compression (mode=0) or d_rounds for finalization (mode=1).
- Provides a per-cycle round strobe, the round index, a last-round flag, a done pulse, hold/stall and abort.
- Sits between the top-level control FSM and the SipRound datapath.

Parameters:
- WIDTH, 4, width of round counts and round index; supports 0..2^WIDTH-1 rounds.
- STICKY_OVR, 1, 1: ovr stays set until reset; 0: ovr is a one-cycle pulse.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a round sequence; sampled each cycle.
- mode  input  1  0 = use c_rounds, 1 = use d_rounds; sampled with start.
- c_rounds  input  WIDTH  compression round count; sampled with start.
- d_rounds  input  WIDTH  finalization round count; sampled with start.
- hold  input  1  stall; freezes the sequence while high.
- abort  input  1  cancel the current sequence.
- busy  output  1  sequence in progress (state RUN).
- round_en  output  1  datapath performs one round this cycle; equals busy & ~hold (combinational).
- round_idx  output  WIDTH  index of the current round, 0..N-1.
- last_round  output  1  busy and round_idx == N-1 (combinational).
- phase  output  1  latched mode of the current or last sequence.
- done  output  1  one-cycle pulse after the final round completes.
- ovr  output  1  start received while busy.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Enters state IDLE.
  - busy=0, round_idx=0, phase=0, done=0, ovr=0; latched N=0.
  - Reset overrides every other input.
- States: IDLE, RUN.
- Priority per edge: reset > abort > normal operation.
- IDLE, start=1, abort=0:
  - Latch N = mode ? d_rounds : c_rounds, and phase = mode.
  - round_idx <= 0.
  - If N != 0: go to RUN; busy=1 from the next cycle.
  - If N == 0: stay in IDLE; done=1 next cycle; round_en never asserts.
- RUN, hold=0, abort=0:
  - If round_idx < N-1: round_idx increments.
  - If round_idx == N-1: go to IDLE, round_idx <= 0, done=1 for exactly the next cycle.
- RUN, hold=1, abort=0: round_idx, state and N are frozen; round_en=0.
- Latency: start at edge k gives busy cycles k+1..k+N (when no hold), with done at cycle k+N+1.
  - Each hold cycle extends the sequence by one cycle.
- Back-to-back: start is accepted in the cycle done=1, because the state is already IDLE.
  - Result: one idle cycle between sequences, and no rounds are lost.
- start while RUN:
  - Ignored; the latched N, phase and round_idx are unchanged.
  - ovr is set next cycle. STICKY_OVR=1: held until reset. STICKY_OVR=0: one-cycle pulse.
- abort=1:
  - Next state IDLE, round_idx=0, busy=0.
  - No done pulse; phase is retained.
  - abort wins over simultaneous start or hold.
  - abort in IDLE is a no-op, and it suppresses a same-cycle start.
- Changes to c_rounds, d_rounds or mode during RUN have no effect.
- Counter width:
  - round_idx never exceeds N-1; no wrap occurs.
  - N = 2^WIDTH-1 (15 at WIDTH=4) runs 15 rounds, indices 0..14.
- done and ovr are registered outputs; round_en and last_round are combinational from registered state and hold.

Test Plan:
- Reset, then start=1, mode=0, c_rounds=2 (WIDTH=4) -> busy high 2 cycles, round_idx 0,1, last_round on idx 1, done pulse in the 3rd cycle, phase=0.
- start, mode=1, d_rounds=4, hold=1 for 2 cycles at idx 1 -> round_idx sequence 0,1,1,1,2,3, round_en low on the held cycles, done 7 cycles after start, phase=1.
- start with c_rounds=0 -> busy stays 0, round_en never asserts, done pulse next cycle.
- Sequence with c_rounds=3, start pulsed again at idx 1 -> sequence unaffected, ovr=1 (sticky), done after 3 rounds; start in the done cycle -> new sequence begins next cycle.
- abort at idx 2 of d_rounds=4, with start asserted the same cycle -> next cycle busy=0, round_idx=0, no done, no new sequence.
- rst_n=0 mid-sequence at idx 5 of 15 -> all outputs return to reset values next cycle; ovr cleared; then d_rounds=15 runs indices 0..14 with no wrap.
